// File: rtl/ahb3lite_pkg.sv
// ahb3lite_pkg: AHB3-Lite encodings and controller types shared by the master controller files
package ahb3lite_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'd0, HTRANS_BUSY = 2'd1, HTRANS_NONSEQ = 2'd2, HTRANS_SEQ = 2'd3;
  localparam logic [2:0] HBURST_SINGLE = 3'd0, HBURST_INCR4 = 3'd3, HBURST_WRAP4 = 3'd2;
  localparam logic [2:0] HSIZE_BYTE = 3'd0, HSIZE_HWORD = 3'd1, HSIZE_WORD = 3'd2;
  localparam logic HRESP_OKAY = 1'b0, HRESP_ERROR = 1'b1;
  typedef enum logic [1:0] {CMD_SINGLE, CMD_INCR4, CMD_WRAP4, CMD_RSVD} cmd_burst_t;
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ERR} state_t;
endpackage

// File: rtl/ahb3lite_master_ctrl_if.sv
// ahb3lite_master_ctrl_if: command, response and AHB3-Lite bus signals of the master controller
// master modport: controller side (takes cmd_*, HRDATA/HREADY/HRESP; drives cmd_ready, H* outputs, rsp_*)
// slave modport: command issuer plus bus slave side
interface ahb3lite_master_ctrl_if #(parameter int HADDR_SIZE = 32, parameter int HDATA_SIZE = 32);
  logic                    cmd_valid, cmd_ready, cmd_write;
  logic [HADDR_SIZE-1:0]   cmd_addr;
  logic [2:0]              cmd_size;
  logic [1:0]              cmd_burst;
  logic [4*HDATA_SIZE-1:0] cmd_wdata;
  logic [HADDR_SIZE-1:0]   HADDR;
  logic                    HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]              HSIZE, HBURST;
  logic [3:0]              HPROT;
  logic [1:0]              HTRANS;
  logic [HDATA_SIZE-1:0]   HWDATA, HRDATA, rsp_rdata;
  logic                    rsp_valid, rsp_err, rsp_last;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst, cmd_wdata, HRDATA, HREADY, HRESP,
    output cmd_ready, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
           rsp_valid, rsp_rdata, rsp_err, rsp_last
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst, cmd_wdata, HRDATA, HREADY, HRESP,
    input  cmd_ready, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
           rsp_valid, rsp_rdata, rsp_err, rsp_last
  );
endinterface

// File: rtl/ahb3lite_addr_gen.sv
// ahb3lite_addr_gen: next beat address for INCR4 (linear) and WRAP4 (wrap within 4*size window)
// ports: addr/size/burst of the current beat in, next_addr out (combinational)
module ahb3lite_addr_gen import ahb3lite_pkg::*; #(parameter int HADDR_SIZE = 32) (
  input  logic [HADDR_SIZE-1:0] addr,
  input  logic [2:0]            size,
  input  cmd_burst_t            burst,
  output logic [HADDR_SIZE-1:0] next_addr
);
  logic [HADDR_SIZE-1:0] inc, mask;
  always_comb begin
    inc = HADDR_SIZE'(1) << size;
    mask = (inc << 2) - HADDR_SIZE'(1);
    next_addr = burst == CMD_WRAP4 ? (addr & ~mask) | ((addr + inc) & mask) : addr + inc;
  end
endmodule

// File: rtl/ahb3lite_master_ctrl.sv
// ahb3lite_master_ctrl: turns single-entry commands into AHB3-Lite SINGLE/INCR4/WRAP4 transfers
// ports: HCLK, HRESETn (async active-low), bus (master modport: cmd_*, AHB H* signals, rsp_*)
module ahb3lite_master_ctrl import ahb3lite_pkg::*; #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input logic                   HCLK,
  input logic                   HRESETn,
  ahb3lite_master_ctrl_if.master bus
);
  typedef struct packed {
    state_t                       st;
    logic                         cmd_ready;
    logic [HADDR_SIZE-1:0]        haddr;
    logic                         hwrite;
    logic [2:0]                   hsize, hburst;
    logic [1:0]                   htrans;
    logic [HDATA_SIZE-1:0]        hwdata;
    logic                         rsp_valid;
    logic [HDATA_SIZE-1:0]        rsp_rdata;
    logic                         rsp_err, rsp_last;
    cmd_burst_t                   burst;
    logic [1:0]                   beat;
    logic                         dp_act, dp_last, dp_write;
    logic [3:0][HDATA_SIZE-1:0]   wdata;
  } regs_t;
  regs_t r, n;
  logic [HADDR_SIZE-1:0] next_addr;
  logic [1:0] last_beat;
  cmd_burst_t cburst;
  assign cburst = cmd_burst_t'(bus.cmd_burst);
  assign last_beat = (r.burst == CMD_INCR4 || r.burst == CMD_WRAP4) ? 2'd3 : 2'd0;
  ahb3lite_addr_gen #(.HADDR_SIZE(HADDR_SIZE)) u_addr_gen (
    .addr(r.haddr), .size(r.hsize), .burst(r.burst), .next_addr(next_addr)
  );
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) r <= '0;
    else r <= n;
  always_comb begin
    n = r;
    n.rsp_valid = 1'b0;
    n.rsp_err = 1'b0;
    n.rsp_last = 1'b0;
    n.rsp_rdata = '0;
    case (r.st)
      S_IDLE: if (bus.cmd_valid && r.cmd_ready) begin
        n.st = S_ADDR;
        n.haddr = bus.cmd_addr & ~((HADDR_SIZE'(1) << bus.cmd_size) - HADDR_SIZE'(1));
        n.hwrite = bus.cmd_write;
        n.hsize = bus.cmd_size;
        n.burst = cburst;
        n.hburst = cburst == CMD_INCR4 ? HBURST_INCR4 : cburst == CMD_WRAP4 ? HBURST_WRAP4 : HBURST_SINGLE;
        n.htrans = HTRANS_NONSEQ;
        n.wdata = bus.cmd_wdata;
        n.beat = 2'd0;
        n.dp_act = 1'b0;
      end
      S_ADDR, S_LAST: if (r.dp_act && bus.HRESP == HRESP_ERROR) begin
        // error cancels every remaining beat; a one-cycle ERROR is handled like the two-cycle form
        n.htrans = HTRANS_IDLE;
        n.st = bus.HREADY ? S_IDLE : S_ERR;
        n.dp_act = !bus.HREADY;
        n.rsp_valid = bus.HREADY;
        n.rsp_err = bus.HREADY;
        n.rsp_last = bus.HREADY;
      end else if (bus.HREADY) begin
        n.rsp_valid = r.dp_act;
        n.rsp_last = r.dp_act && r.dp_last;
        n.rsp_rdata = r.dp_act && !r.dp_write ? bus.HRDATA : '0;
        if (r.st == S_LAST) begin
          n.st = S_IDLE;
          n.dp_act = 1'b0;
        end else begin
          n.dp_act = 1'b1;
          n.dp_last = r.beat == last_beat;
          n.dp_write = r.hwrite;
          n.hwdata = r.hwrite ? r.wdata[r.beat] : r.hwdata;
          n.st = r.beat == last_beat ? S_LAST : S_ADDR;
          n.htrans = r.beat == last_beat ? HTRANS_IDLE : HTRANS_SEQ;
          n.haddr = r.beat == last_beat ? r.haddr : next_addr;
          n.beat = r.beat == last_beat ? r.beat : r.beat + 2'd1;
        end
      end
      S_ERR: if (bus.HREADY) begin
        n.st = S_IDLE;
        n.dp_act = 1'b0;
        n.rsp_valid = 1'b1;
        n.rsp_err = 1'b1;
        n.rsp_last = 1'b1;
      end
    endcase
    n.cmd_ready = n.st == S_IDLE;
  end
  assign bus.cmd_ready = r.cmd_ready;
  assign bus.HADDR = r.haddr;
  assign bus.HWRITE = r.hwrite;
  assign bus.HSIZE = r.hsize;
  assign bus.HBURST = r.hburst;
  assign bus.HPROT = 4'b0011;
  assign bus.HTRANS = r.htrans;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HWDATA = r.hwdata;
  assign bus.rsp_valid = r.rsp_valid;
  assign bus.rsp_rdata = r.rsp_rdata;
  assign bus.rsp_err = r.rsp_err;
  assign bus.rsp_last = r.rsp_last;
endmodule

// File: tb/tb_ahb3lite_master_ctrl.sv
// tb_ahb3lite_master_ctrl: directed bench for ahb3lite_master_ctrl against a word SRAM slave model
module tb_ahb3lite_master_ctrl;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b1;
  int checks = 0;
  int errors = 0;
  int x0;
  logic [31:0] wv [4];
  ahb3lite_master_ctrl_if bus();
  ahb3lite_master_ctrl dut (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus));
  always #5 HCLK = ~HCLK;
  logic [31:0] mem [64];
  logic [31:0] ap_addr;
  logic ap_valid, ap_write;
  int xfers;
  always @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 | 32'(i * 4);
      ap_valid <= 1'b0;
      ap_write <= 1'b0;
      ap_addr <= '0;
      xfers <= 0;
    end else if (bus.HREADY) begin
      if (ap_valid && ap_write) mem[ap_addr[7:2]] <= bus.HWDATA;
      ap_valid <= bus.HTRANS[1];
      ap_write <= bus.HWRITE;
      ap_addr <= bus.HADDR;
      if (bus.HTRANS[1]) xfers <= xfers + 1;
    end
  end
  assign bus.HRDATA = (ap_valid && !ap_write) ? mem[ap_addr[7:2]] : 32'h0;
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [1:0] bt, input logic [127:0] wd);
    chk("issue_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr = a;
    bus.cmd_size = s;
    bus.cmd_burst = bt;
    bus.cmd_wdata = wd;
    tick();
    bus.cmd_valid = 1'b0;
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_size = '0;
    bus.cmd_burst = '0;
    bus.cmd_wdata = '0;
    bus.HREADY = 1'b1;
    bus.HRESP = 1'b0;
    #2 HRESETn = 1'b0;
    tick();
    tick();
    chk("rst_htrans", 32'(bus.HTRANS), 32'd0);
    chk("rst_haddr", bus.HADDR, 32'd0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_hprot", 32'(bus.HPROT), 32'd3);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    HRESETn = 1'b1;
    tick();
    chk("rel_ready", 32'(bus.cmd_ready), 32'd1);
    issue(1'b1, 32'h10, 3'd2, 2'd0, {96'h0, 32'hDEADBEEF});
    chk("wr_htrans", 32'(bus.HTRANS), 32'd2);
    chk("wr_hwrite", 32'(bus.HWRITE), 32'd1);
    chk("wr_haddr", bus.HADDR, 32'h10);
    chk("wr_hburst", 32'(bus.HBURST), 32'd0);
    chk("wr_ready_low", 32'(bus.cmd_ready), 32'd0);
    tick();
    chk("wr_hwdata", bus.HWDATA, 32'hDEADBEEF);
    chk("wr_htrans_idle", 32'(bus.HTRANS), 32'd0);
    tick();
    chk("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("wr_rsp_last", 32'(bus.rsp_last), 32'd1);
    chk("wr_rsp_rdata", bus.rsp_rdata, 32'd0);
    issue(1'b0, 32'h10, 3'd2, 2'd0, 128'h0);
    chk("rd_htrans", 32'(bus.HTRANS), 32'd2);
    chk("rd_hwrite", 32'(bus.HWRITE), 32'd0);
    tick();
    chk("rd_rsp_early", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rd_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    chk("rd_rsp_last", 32'(bus.rsp_last), 32'd1);
    issue(1'b0, 32'h20, 3'd2, 2'd1, 128'h0);
    chk("i4_hburst", 32'(bus.HBURST), 32'd3);
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        chk($sformatf("i4_haddr%0d", k), bus.HADDR, 32'h20 + 32'(4 * k));
        chk($sformatf("i4_htrans%0d", k), 32'(bus.HTRANS), k == 0 ? 32'd2 : 32'd3);
      end else chk("i4_htrans_idle", 32'(bus.HTRANS), 32'd0);
      chk($sformatf("i4_rsp_valid%0d", k), 32'(bus.rsp_valid), 32'(k >= 2));
      if (k >= 2) begin
        chk($sformatf("i4_rdata%0d", k), bus.rsp_rdata, 32'hA000_0020 + 32'(4 * (k - 2)));
        chk($sformatf("i4_last%0d", k), 32'(bus.rsp_last), 32'(k == 5));
      end
      if (k < 5) tick();
    end
    chk("i4_ready_back", 32'(bus.cmd_ready), 32'd1);
    wv[0] = 32'hAAAA_0001;
    wv[1] = 32'hBBBB_0002;
    wv[2] = 32'hCCCC_0003;
    wv[3] = 32'hDDDD_0004;
    issue(1'b1, 32'h38, 3'd2, 2'd2, {wv[3], wv[2], wv[1], wv[0]});
    chk("w4_hburst", 32'(bus.HBURST), 32'd2);
    for (int k = 0; k < 6; k++) begin
      if (k < 4) chk($sformatf("w4_haddr%0d", k), bus.HADDR, k == 0 ? 32'h38 : k == 1 ? 32'h3C : k == 2 ? 32'h30 : 32'h34);
      if (k >= 1 && k <= 4) chk($sformatf("w4_hwdata%0d", k), bus.HWDATA, wv[k - 1]);
      chk($sformatf("w4_rsp_valid%0d", k), 32'(bus.rsp_valid), 32'(k >= 2));
      if (k < 5) tick();
    end
    chk("w4_last", 32'(bus.rsp_last), 32'd1);
    chk("w4_mem30", mem[12], wv[2]);
    chk("w4_mem34", mem[13], wv[3]);
    chk("w4_mem38", mem[14], wv[0]);
    chk("w4_mem3c", mem[15], wv[1]);
    wv[0] = 32'h1111_0000;
    wv[1] = 32'h1111_0001;
    wv[2] = 32'h1111_0002;
    wv[3] = 32'h1111_0003;
    issue(1'b1, 32'h20, 3'd2, 2'd1, {wv[3], wv[2], wv[1], wv[0]});
    tick();
    tick();
    chk("ws_rsp0", 32'(bus.rsp_valid), 32'd1);
    bus.HREADY = 1'b0;
    for (int k = 3; k < 5; k++) begin
      tick();
      chk($sformatf("ws_haddr%0d", k), bus.HADDR, 32'h28);
      chk($sformatf("ws_hwdata%0d", k), bus.HWDATA, wv[1]);
      chk($sformatf("ws_htrans%0d", k), 32'(bus.HTRANS), 32'd3);
      chk($sformatf("ws_rsp%0d", k), 32'(bus.rsp_valid), 32'd0);
    end
    bus.HREADY = 1'b1;
    tick();
    chk("ws_rsp1", 32'(bus.rsp_valid), 32'd1);
    chk("ws_haddr5", bus.HADDR, 32'h2C);
    chk("ws_hwdata5", bus.HWDATA, wv[2]);
    tick();
    chk("ws_rsp2_notlast", 32'(bus.rsp_last), 32'd0);
    chk("ws_hwdata6", bus.HWDATA, wv[3]);
    tick();
    chk("ws_rsp3", 32'(bus.rsp_valid), 32'd1);
    chk("ws_rsp3_last", 32'(bus.rsp_last), 32'd1);
    chk("ws_mem24", mem[9], wv[1]);
    chk("ws_mem2c", mem[11], wv[3]);
    x0 = xfers;
    issue(1'b0, 32'h20, 3'd2, 2'd1, 128'h0);
    tick();
    tick();
    bus.HREADY = 1'b0;
    bus.HRESP = 1'b1;
    tick();
    chk("er_htrans", 32'(bus.HTRANS), 32'd0);
    chk("er_rsp_first", 32'(bus.rsp_valid), 32'd0);
    bus.HREADY = 1'b1;
    tick();
    chk("er_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("er_rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("er_rsp_last", 32'(bus.rsp_last), 32'd1);
    bus.HRESP = 1'b0;
    tick();
    chk("er_rsp_after", 32'(bus.rsp_valid), 32'd0);
    chk("er_htrans_after", 32'(bus.HTRANS), 32'd0);
    chk("er_ready", 32'(bus.cmd_ready), 32'd1);
    chk("er_xfers", 32'(xfers - x0), 32'd2);
    issue(1'b0, 32'h0, 3'd2, 2'd0, 128'h0);
    tick();
    bus.HRESP = 1'b1;
    tick();
    chk("pv_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("pv_rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("pv_rsp_last", 32'(bus.rsp_last), 32'd1);
    bus.HRESP = 1'b0;
    tick();
    chk("pv_rsp_after", 32'(bus.rsp_valid), 32'd0);
    issue(1'b0, 32'h13, 3'd1, 2'd3, 128'h0);
    chk("hw_haddr", bus.HADDR, 32'h12);
    chk("hw_hsize", 32'(bus.HSIZE), 32'd1);
    chk("hw_hburst", 32'(bus.HBURST), 32'd0);
    chk("hw_htrans", 32'(bus.HTRANS), 32'd2);
    tick();
    tick();
    chk("hw_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("hw_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    chk("hw_rsp_last", 32'(bus.rsp_last), 32'd1);
    chk("hw_rsp_err", 32'(bus.rsp_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
